// File: rtl/menu_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : menu_pkg
// Description : Shared types, default menu geometry and cursor arithmetic
//               for the three-level menu controller.
// Revision    : 1.0 - initial release
// ============================================================================
package menu_pkg;

    // Menu level encoding; the fourth code is unused and self-heals to L_MAIN.
    typedef enum logic [1:0] {
        L_MAIN    = 2'd0,
        L_SUB     = 2'd1,
        L_CONFIRM = 2'd2
    } level_t;

    // Default geometry: four main entries, per-entry highest sub index packed
    // two bits per main choice (slice [2k+1:2k] belongs to main choice k).
    localparam logic [1:0] c_main_top_default = 2'd3;
    localparam logic [7:0] c_sub_tops_default = 8'b11_10_01_11;

    // One cursor step. Wrap is decided by comparing against the bounds so the
    // cursor can never leave [0, top] even when top is not 2'd3.
    function automatic logic [1:0] cursor_next(
        input logic [1:0] cur,
        input logic [1:0] top,
        input logic       up,
        input logic       down
    );
        logic [1:0] nxt;
        nxt = cur;
        if (up && !down) begin
            nxt = (cur == 2'd0) ? top : cur - 2'd1;
        end else if (down && !up) begin
            nxt = (cur == top) ? 2'd0 : cur + 2'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/menu_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : menu_if
// Description : Button inputs and menu state outputs of the menu controller.
//               master = button/display side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface menu_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_select;
    logic       btn_back;
    logic [1:0] level;
    logic [1:0] main_choice;
    logic [1:0] sub_choice;
    logic [1:0] cfg_mode;
    logic [1:0] cfg_option;
    logic       cfg_valid;

    modport master (
        output btn_up, btn_down, btn_select, btn_back,
        input  level, main_choice, sub_choice, cfg_mode, cfg_option, cfg_valid
    );

    modport slave (
        input  btn_up, btn_down, btn_select, btn_back,
        output level, main_choice, sub_choice, cfg_mode, cfg_option, cfg_valid
    );
endinterface
`default_nettype wire

// File: rtl/menu_controller_btn_pulse.sv
`default_nettype none
// ============================================================================
// Module      : btn_pulse
// Description : Rising-edge detector for a debounced, synchronous button
//               level. The pulse is combinational from the current level so
//               the consumer acts on the same edge that samples the press.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_pulse (
    input  wire logic clk_in,
    input  wire logic rst_n_in,
    input  wire logic level_i,
    output logic      pulse_o
);

    logic hist_q;

    // History resets to 1 so a button held through reset is not seen as a press.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~hist_q;

endmodule
`default_nettype wire

// File: rtl/menu_controller.sv
`default_nettype none
// ============================================================================
// Module      : menu_controller
// Description : Three-level menu navigator (main -> sub -> confirm) driven by
//               four push buttons; commits a (mode, option) pair with a
//               one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module menu_controller
    import menu_pkg::*;
#(
    parameter logic [1:0] MAIN_TOP = c_main_top_default,
    parameter logic [7:0] SUB_TOPS = c_sub_tops_default
) (
    input  wire logic clk_in,
    input  wire logic rst_n_in,
    menu_if.slave     bus
);

    // ------------------------------------------------------------------
    // Button press events
    // ------------------------------------------------------------------
    logic [3:0] w_lvl;
    logic [3:0] w_evt;
    logic       w_up;
    logic       w_down;
    logic       w_sel;
    logic       w_back;

    assign w_lvl = {bus.btn_back, bus.btn_select, bus.btn_down, bus.btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_pulse u_pulse (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .level_i  (w_lvl[i]),
            .pulse_o  (w_evt[i])
        );
    end

    assign w_up   = w_evt[0];
    assign w_down = w_evt[1];
    assign w_sel  = w_evt[2];
    assign w_back = w_evt[3];

    // Select and back cancel each other; any level event masks cursor moves.
    logic w_sel_only;
    logic w_back_only;
    logic w_nav;

    assign w_sel_only  = w_sel & ~w_back;
    assign w_back_only = w_back & ~w_sel;
    assign w_nav       = ~w_sel & ~w_back;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    level_t     state_q, state_d;
    logic [1:0] main_q, main_d;
    logic [1:0] sub_q, sub_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] option_q, option_d;
    logic       valid_q, valid_d;
    logic [1:0] w_sub_top;

    // Sub-menu depth depends on which main entry was entered.
    assign w_sub_top = SUB_TOPS[{main_q, 1'b0} +: 2];

    // State register: everything clears asynchronously, including the pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= L_MAIN;
            main_q   <= 2'd0;
            sub_q    <= 2'd0;
            mode_q   <= 2'd0;
            option_q <= 2'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            sub_q    <= sub_d;
            mode_q   <= mode_d;
            option_q <= option_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state: level transitions, cursor moves and commit.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        sub_d    = sub_q;
        mode_d   = mode_q;
        option_d = option_q;
        valid_d  = 1'b0;

        case (state_q)
            L_MAIN: begin
                if (w_sel_only) begin
                    state_d = L_SUB;
                    sub_d   = 2'd0;
                end else if (w_nav) begin
                    main_d = cursor_next(main_q, MAIN_TOP, w_up, w_down);
                end
            end
            L_SUB: begin
                if (w_sel_only) begin
                    state_d = L_CONFIRM;
                end else if (w_back_only) begin
                    state_d = L_MAIN;
                end else if (w_nav) begin
                    sub_d = cursor_next(sub_q, w_sub_top, w_up, w_down);
                end
            end
            L_CONFIRM: begin
                if (w_sel_only) begin
                    state_d  = L_MAIN;
                    mode_d   = main_q;
                    option_d = sub_q;
                    valid_d  = 1'b1;
                end else if (w_back_only) begin
                    state_d = L_SUB;
                end
            end
            default: begin
                state_d = L_MAIN;
            end
        endcase
    end

    assign bus.level       = state_q;
    assign bus.main_choice = main_q;
    assign bus.sub_choice  = sub_q;
    assign bus.cfg_mode    = mode_q;
    assign bus.cfg_option  = option_q;
    assign bus.cfg_valid   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_menu_controller
// Description : Self-checking bench for menu_controller: a table of single
//               button presses with expected outputs, then hand-written
//               sequences for held buttons and reset during the commit pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_controller;

    logic clk_in;
    logic rst_n_in;

    menu_if bus ();

    menu_controller dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // {up, down, select, back}
    typedef struct {
        logic [3:0]  btn;
        logic [10:0] exp;
    } vec_t;

    int          tests;
    int          failed;
    logic [10:0] sb[$];
    vec_t        tbl[25];

    // Expected-output word: {level, main, sub, mode, option, valid}
    function automatic logic [10:0] ex(input logic [1:0] lvl, input logic [1:0] m,
                                       input logic [1:0] s, input logic [1:0] md,
                                       input logic [1:0] op, input logic v);
        return {lvl, m, s, md, op, v};
    endfunction

    function automatic logic [10:0] observed();
        return {bus.level, bus.main_choice, bus.sub_choice,
                bus.cfg_mode, bus.cfg_option, bus.cfg_valid};
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b required %b (lvl,main,sub,mode,opt,valid)", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {bus.btn_up, bus.btn_down, bus.btn_select, bus.btn_back} = b;
    endtask

    // One press: drive for one edge, check, then release for one edge.
    task automatic press(input string name, input logic [3:0] b, input logic [10:0] exp);
        logic [10:0] e;
        @(negedge clk_in);
        set_btn(b);
        sb.push_back(exp);
        @(posedge clk_in);
        #1;
        e = sb.pop_front();
        chk(name, observed(), e);
        @(negedge clk_in);
        set_btn(4'b0000);
    endtask

    localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, SEL = 4'b0010, BK = 4'b0001;
    localparam logic [1:0] M = 2'd0, S = 2'd1, C = 2'd2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests  = 0;
        failed = 0;

        // Default geometry: main top 3; sub tops 3,1,2,3 for main 0..3.
        tbl[0]  = '{DN,       ex(M, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[1]  = '{DN,       ex(M, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[2]  = '{DN,       ex(M, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[3]  = '{DN,       ex(M, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[4]  = '{BK,       ex(M, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[5]  = '{UP,       ex(M, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[6]  = '{UP,       ex(M, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[7]  = '{UP,       ex(M, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[8]  = '{SEL,      ex(S, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[9]  = '{UP,       ex(S, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0)};
        tbl[10] = '{DN,       ex(S, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[11] = '{DN,       ex(S, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0)};
        tbl[12] = '{BK,       ex(M, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0)};
        tbl[13] = '{DN,       ex(M, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0)};
        tbl[14] = '{SEL,      ex(S, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0)};
        tbl[15] = '{DN,       ex(S, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0)};
        tbl[16] = '{SEL,      ex(C, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0)};
        tbl[17] = '{UP,       ex(C, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0)};
        tbl[18] = '{BK,       ex(S, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0)};
        tbl[19] = '{SEL,      ex(C, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0)};
        tbl[20] = '{SEL,      ex(M, 2'd2, 2'd1, 2'd2, 2'd1, 1'b1)};
        tbl[21] = '{UP | DN,  ex(M, 2'd2, 2'd1, 2'd2, 2'd1, 1'b0)};
        tbl[22] = '{SEL | BK, ex(M, 2'd2, 2'd1, 2'd2, 2'd1, 1'b0)};
        tbl[23] = '{SEL | DN, ex(S, 2'd2, 2'd0, 2'd2, 2'd1, 1'b0)};
        tbl[24] = '{BK | UP,  ex(M, 2'd2, 2'd0, 2'd2, 2'd1, 1'b0)};

        // Reset with idle buttons
        rst_n_in = 1'b0;
        set_btn(4'b0000);
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_state", observed(), 11'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        for (int i = 0; i < 25; i++) begin
            press($sformatf("vec%0d", i), tbl[i].btn, tbl[i].exp);
        end

        // Held down for ten cycles: a single increment (main 2 -> 3)
        @(negedge clk_in);
        set_btn(DN);
        repeat (10) @(posedge clk_in);
        #1;
        chk("held_down", observed(), ex(M, 2'd3, 2'd0, 2'd2, 2'd1, 1'b0));
        @(negedge clk_in);
        set_btn(4'b0000);

        // Walk to confirm under main 3 (sub top 3)
        press("walk_sel",  SEL, ex(S, 2'd3, 2'd0, 2'd2, 2'd1, 1'b0));
        press("walk_up",   UP,  ex(S, 2'd3, 2'd3, 2'd2, 2'd1, 1'b0));
        press("walk_sel2", SEL, ex(C, 2'd3, 2'd3, 2'd2, 2'd1, 1'b0));

        // Commit, then reset inside the pulse cycle before the next edge
        @(negedge clk_in);
        set_btn(SEL);
        @(posedge clk_in);
        #1;
        chk("commit_pulse", observed(), ex(M, 2'd3, 2'd3, 2'd3, 2'd3, 1'b1));
        #1;
        rst_n_in = 1'b0;
        set_btn(DN | SEL);
        #1;
        chk("reset_in_pulse", observed(), 11'd0);

        // Buttons held through reset release: no events
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("held_thru_reset", observed(), 11'd0);
        @(negedge clk_in);
        set_btn(4'b0000);

        press("post_reset_down", DN, ex(M, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0));

        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/menu_controller.md
MENU_CONTROLLER -- requirements
Module: menu_controller

Interface
REQ-001 Parameter MAIN_TOP, default 2'd3: highest main-menu index. Lowest index is always 0.
REQ-002 Parameter SUB_TOPS, default 8'b11_10_01_11: packed 4x2-bit highest sub-menu index per main choice; slice [2k+1:2k] applies to main choice k.
REQ-003 clk_in  input  1  system clock; one clock domain.
REQ-004 rst_n_in  input  1  reset; asynchronous assertion, active-low.
REQ-005 btn_up  input  1  debounced, synchronous level; up moves the cursor toward index 0.
REQ-006 btn_down  input  1  debounced, synchronous level; down moves the cursor toward the top index.
REQ-007 btn_select  input  1  debounced, synchronous level; enter, confirm or commit.
REQ-008 btn_back  input  1  debounced, synchronous level; leave the current level.
REQ-009 level  output  2  current state, encoded as a level_t value.
REQ-010 main_choice  output  2  main-menu cursor.
REQ-011 sub_choice  output  2  sub-menu cursor.
REQ-012 cfg_mode  output  2  last committed main choice.
REQ-013 cfg_option  output  2  last committed sub choice.
REQ-014 cfg_valid  output  1  one-cycle pulse on commit.

Function
REQ-015 Each button SHALL produce a press event only on a clock edge where the level is sampled 1 and the previous sample was 0; a held level SHALL produce no further events.
REQ-016 The FSM SHALL have exactly three states: L_MAIN, L_SUB and L_CONFIRM.
REQ-017 Cursor moves in L_MAIN and L_SUB:
  - up at index 0 wraps to the top index; otherwise up decrements the index.
  - down at the top index wraps to 0; otherwise down increments the index.
  - State, cursors and outputs update on the same edge that detects the press (zero added latency).
REQ-018 In L_MAIN, the top index is MAIN_TOP. In L_SUB, the top index is the SUB_TOPS slice selected by main_choice.
REQ-019 Transitions on select:
  - L_MAIN -> L_SUB; sub_choice loads 0.
  - L_SUB -> L_CONFIRM.
  - L_CONFIRM -> L_MAIN; cfg_mode and cfg_option latch main_choice and sub_choice; main_choice is retained.
REQ-020 cfg_valid SHALL be 1 for exactly the one cycle following the commit edge, and 0 at all other times.
REQ-021 Transitions on back:
  - L_CONFIRM -> L_SUB; sub_choice retained.
  - L_SUB -> L_MAIN; main_choice retained.
  - In L_MAIN, back SHALL be ignored.
REQ-022 Priority when events coincide:
  - select and back in the same cycle: both ignored.
  - select or back together with up/down: the level change wins and up/down are ignored.
  - up and down in the same cycle: both ignored.
REQ-023 In L_CONFIRM, up and down SHALL be ignored.
REQ-024 Cursor arithmetic SHALL be 2-bit, with wrap handled explicitly by comparison against the top index, never by overflow.
REQ-025 No input combination SHALL drive level to the unused encoding. If it is reached anyway, the next edge SHALL return the FSM to L_MAIN.

Reset
REQ-026 While rst_n_in is 0, all outputs and state SHALL take these values asynchronously:
  - level = L_MAIN
  - main_choice = sub_choice = cfg_mode = cfg_option = 0
  - cfg_valid = 0
  - button history registers = 1, so a button held through reset creates no event
REQ-027 Reset asserted mid-operation, including during the cfg_valid cycle, SHALL clear the pulse immediately and discard any uncommitted selection.

Structure
REQ-028 Package menu_pkg SHALL hold typedef level_t (L_MAIN=0, L_SUB=1, L_CONFIRM=2) and the default constants for MAIN_TOP and SUB_TOPS.
REQ-029 Edge detection SHALL be one sub-module, btn_pulse (clk_in, rst_n_in, level in, pulse out), instantiated four times.
REQ-030 Expected implementation size: 150-300 lines of RTL.

Verification
REQ-031 Reset, then down x4 in L_MAIN -> main_choice sequence 1, 2, 3, 0; level stays L_MAIN.
REQ-032 main_choice=1 (SUB top 2'd1); select, then up -> level L_SUB, sub_choice 0 -> 1 (wrap); then down -> sub_choice 0.
REQ-033 main=2, sub=1; select, select -> L_CONFIRM; select -> cfg_valid high for 1 cycle, cfg_mode=2, cfg_option=1, level L_MAIN, main_choice=2.
REQ-034 From L_CONFIRM: back -> L_SUB with sub_choice unchanged; back -> L_MAIN; back again -> no change.
REQ-035 btn_down held high for 10 cycles -> exactly one increment. select+back in the same cycle -> no change. up+down in the same cycle -> no change.
REQ-036 rst_n_in pulsed low in the cycle cfg_valid is high -> cfg_valid, cfg_mode and cfg_option read 0 before the next clk_in edge; buttons held through reset produce no event after release of reset.
